// File: rtl/bus_interconnect.sv
// -----------------------------------------------------------------------------
// bus_interconnect
//
// Single-master, N-slave memory-bus interconnect. It registers one CPU request
// at a time and decodes it against per-slave address windows. The request goes
// to exactly one slave as a single-cycle valid pulse. The interconnect then
// waits for that slave's ready and returns a registered one-cycle response.
// It also returns an error response for an unmapped address or for a slave
// that does not answer within TIMEOUT cycles. Ready pulses from slaves that
// are not selected are ignored, and so are ready pulses that arrive outside
// the request/wait window.
//
// Ports:
//   clk           in   clock
//   rst           in   asynchronous active-low reset
//   memory_valid  in   single-cycle request pulse from the master
//   memory_instr  in   instruction-fetch flag
//   memory_addr   in   [31:0] byte address
//   memory_wdata  in   [31:0] write data
//   memory_wstrb  in   [3:0] byte strobes, 0 = read
//   memory_rdata  out  [31:0] response data, held until the next response
//   memory_ready  out  single-cycle response pulse
//   memory_error  out  qualifies memory_ready: unmapped address or timeout
//   slave_valid   out  [NUM_SLAVES-1:0] one-hot single-cycle request
//   slave_instr   out  latched instr, shared by all slaves
//   slave_addr    out  [31:0] latched address minus the selected window base
//   slave_wdata   out  [31:0] latched write data, shared
//   slave_wstrb   out  [3:0] latched strobes, shared
//   slave_rdata   in   [NUM_SLAVES*32-1:0] slave read data, slave i at [32*i +: 32]
//   slave_ready   in   [NUM_SLAVES-1:0] slave response pulses
// -----------------------------------------------------------------------------
module bus_interconnect #(
   parameter int                       NUM_SLAVES = 3,
   // Slave i owns bits [32*i +: 32], so the rightmost literal is slave 0.
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h0020_0000, 32'h0010_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_TOP  = {32'h0020_0010, 32'h0010_0010, 32'h0010_0000},
   parameter int                       TIMEOUT    = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       memory_valid,
   input  logic                       memory_instr,
   input  logic [31:0]                memory_addr,
   input  logic [31:0]                memory_wdata,
   input  logic [3:0]                 memory_wstrb,
   output logic [31:0]                memory_rdata,
   output logic                       memory_ready,
   output logic                       memory_error,
   output logic [NUM_SLAVES-1:0]      slave_valid,
   output logic                       slave_instr,
   output logic [31:0]                slave_addr,
   output logic [31:0]                slave_wdata,
   output logic [3:0]                 slave_wstrb,
   input  logic [NUM_SLAVES*32-1:0]   slave_rdata,
   input  logic [NUM_SLAVES-1:0]      slave_ready
);

   localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic            instr_q, instr_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            err_q, err_d;

   // ---------------------------------------------------------------------------
   // Address decode: per-window hit, then lowest-index priority
   // ---------------------------------------------------------------------------
   logic [NUM_SLAVES-1:0] hit;
   logic                  dec_hit;
   logic [SW-1:0]         dec_idx;
   logic [31:0]           dec_base;

   for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
      assign hit[gi] = (memory_addr >= SLAVE_BASE[32*gi +: 32]) &&
                       (memory_addr <  SLAVE_TOP[32*gi +: 32]);
   end

   // Scanning downwards lets the lowest matching index overwrite the others,
   // so overlapping windows resolve to the lowest slave number.
   always_comb begin
      dec_hit  = 1'b0;
      dec_idx  = '0;
      dec_base = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            dec_hit  = 1'b1;
            dec_idx  = SW'(i);
            dec_base = SLAVE_BASE[32*i +: 32];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Selected-slave response mux; every other slave's ready is invisible here
   // ---------------------------------------------------------------------------
   logic        sel_ready;
   logic [31:0] sel_rdata;

   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q == SW'(i)) begin
            sel_ready = slave_ready[i];
            sel_rdata = slave_rdata[32*i +: 32];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   logic [CW-1:0] cnt_inc;
   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      instr_d = instr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      unique case (state_q)
         S_IDLE: begin
            if (memory_valid) begin
               sel_d   = dec_idx;
               instr_d = memory_instr;
               wdata_d = memory_wdata;
               wstrb_d = memory_wstrb;
               if (dec_hit) begin
                  // Slaves see an offset relative to their own window.
                  addr_d  = memory_addr - dec_base;
                  state_d = S_REQ;
               end else begin
                  addr_d  = memory_addr;
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
            end
         end

         S_REQ: begin
            cnt_d = '0;
            if (sel_ready) begin
               rdata_d = sel_rdata;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            // Ready is tested first so a response on the final cycle still wins.
            if (sel_ready) begin
               rdata_d = sel_rdata;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CW'(TIMEOUT - 1)) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
            end
         end

         S_RESP: begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         instr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         instr_q <= instr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: decoded from registers only, so they go low with the reset
   // ---------------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_valid
      assign slave_valid[gi] = (state_q == S_REQ) && (sel_q == SW'(gi));
   end

   assign slave_instr  = instr_q;
   assign slave_addr   = addr_q;
   assign slave_wdata  = wdata_q;
   assign slave_wstrb  = wstrb_q;
   assign memory_ready = (state_q == S_RESP);
   assign memory_error = (state_q == S_RESP) && err_q;
   assign memory_rdata = rdata_q;

endmodule

// File: tb/tb_bus_interconnect.sv
module tb_bus_interconnect;

   localparam int NS = 3;
   localparam int TO = 8;
   // Slave 2's window overlaps the upper half of slave 1's window.
   localparam logic [NS*32-1:0] BASE_P = {32'h0010_0008, 32'h0010_0000, 32'h0000_0000};
   localparam logic [NS*32-1:0] TOP_P  = {32'h0010_0020, 32'h0010_0010, 32'h0010_0000};

   logic [31:0] base_m [NS] = '{32'h0000_0000, 32'h0010_0000, 32'h0010_0008};
   logic [31:0] top_m  [NS] = '{32'h0010_0000, 32'h0010_0010, 32'h0010_0020};

   logic              clk;
   logic              rst;
   logic              memory_valid;
   logic              memory_instr;
   logic [31:0]       memory_addr;
   logic [31:0]       memory_wdata;
   logic [3:0]        memory_wstrb;
   logic [31:0]       memory_rdata;
   logic              memory_ready;
   logic              memory_error;
   logic [NS-1:0]     slave_valid;
   logic              slave_instr;
   logic [31:0]       slave_addr;
   logic [31:0]       slave_wdata;
   logic [3:0]        slave_wstrb;
   logic [NS*32-1:0]  slave_rdata;
   logic [NS-1:0]     slave_ready;

   bus_interconnect #(
      .NUM_SLAVES (NS),
      .SLAVE_BASE (BASE_P),
      .SLAVE_TOP  (TOP_P),
      .TIMEOUT    (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .memory_valid (memory_valid),
      .memory_instr (memory_instr),
      .memory_addr  (memory_addr),
      .memory_wdata (memory_wdata),
      .memory_wstrb (memory_wstrb),
      .memory_rdata (memory_rdata),
      .memory_ready (memory_ready),
      .memory_error (memory_error),
      .slave_valid  (slave_valid),
      .slave_instr  (slave_instr),
      .slave_addr   (slave_addr),
      .slave_wdata  (slave_wdata),
      .slave_wstrb  (slave_wstrb),
      .slave_rdata  (slave_rdata),
      .slave_ready  (slave_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int ncyc = 0;
   always @(posedge clk) ncyc <= ncyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   typedef struct {
      int          cyc;
      logic [NS-1:0] oh;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        instr;
   } sreq_t;

   resp_t       rq[$];
   sreq_t       sq[$];
   int          errors = 0;
   int          checks = 0;
   int          txn_no = 0;
   logic [31:0] last_rdata = '0;
   resp_t       mr;
   sreq_t       ms;

   // Reference decode: first window (lowest index) containing the address.
   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < NS; i++)
         if (a >= base_m[i] && a < top_m[i]) return i;
      return -1;
   endfunction

   // ---------------------------------------------------------------------------
   // Monitor: pops expectations whenever the DUT presents a request or response
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (rst) begin
         if (slave_valid != '0) begin
            checks++;
            if (sq.size() == 0) begin
               errors++;
               $display("FAIL slave_req_unexpected: cyc=%0d slave_valid=%b, required no request", ncyc, slave_valid);
            end else begin
               ms = sq.pop_front();
               if (ncyc != ms.cyc || slave_valid !== ms.oh || slave_addr !== ms.addr ||
                   slave_wdata !== ms.wdata || slave_wstrb !== ms.wstrb || slave_instr !== ms.instr) begin
                  errors++;
                  $display("FAIL slave_req: got cyc=%0d valid=%b addr=%h wdata=%h wstrb=%b instr=%b, required cyc=%0d valid=%b addr=%h wdata=%h wstrb=%b instr=%b",
                           ncyc, slave_valid, slave_addr, slave_wdata, slave_wstrb, slave_instr,
                           ms.cyc, ms.oh, ms.addr, ms.wdata, ms.wstrb, ms.instr);
               end
            end
         end
         if (memory_ready === 1'b1) begin
            checks++;
            if (rq.size() == 0) begin
               errors++;
               $display("FAIL resp_unexpected: cyc=%0d rdata=%h error=%b, required no response", ncyc, memory_rdata, memory_error);
            end else begin
               mr = rq.pop_front();
               last_rdata = mr.rdata;
               if (ncyc != mr.cyc || memory_rdata !== mr.rdata || memory_error !== mr.err) begin
                  errors++;
                  $display("FAIL resp: got cyc=%0d rdata=%h error=%b, required cyc=%0d rdata=%h error=%b",
                           ncyc, memory_rdata, memory_error, mr.cyc, mr.rdata, mr.err);
               end
            end
         end else begin
            checks++;
            if (memory_ready !== 1'b0 || memory_error !== 1'b0 || memory_rdata !== last_rdata) begin
               errors++;
               $display("FAIL idle_hold: cyc=%0d ready=%b error=%b rdata=%h, required ready=0 error=0 rdata=%h",
                        ncyc, memory_ready, memory_error, memory_rdata, last_rdata);
            end
         end
      end
   end

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({memory_ready, memory_error, memory_rdata, slave_valid, slave_instr,
           slave_addr, slave_wdata, slave_wstrb} !== '0) begin
         errors++;
         $display("FAIL %s: ready=%b error=%b rdata=%h slave_valid=%b instr=%b addr=%h wdata=%h wstrb=%b, required all zero",
                  name, memory_ready, memory_error, memory_rdata, slave_valid, slave_instr,
                  slave_addr, slave_wdata, slave_wstrb);
      end
   endtask

   // ---------------------------------------------------------------------------
   // One transaction: master request, slave behaviour, optional reset abort.
   // k = cycles from slave_valid to slave ready; k >= TO gives a late ready.
   // ---------------------------------------------------------------------------
   task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr, input int k,
                         input logic [31:0] rd, input bit stray, input int rst_at);
      int    sel;
      int    n;
      int    rel;
      int    last;
      int    o;
      bit    ok_data;
      bit    aborted;
      resp_t r;
      sreq_t s;

      sel     = decode(addr);
      ok_data = (sel >= 0) && (k <= TO - 1);
      if (sel < 0)      rel = 1;
      else if (ok_data) rel = 2 + k;
      else              rel = 1 + TO;

      @(negedge clk);
      n = ncyc;
      if (sel >= 0) begin
         s.cyc   = n + 1;
         s.oh    = '0;
         s.oh[sel] = 1'b1;
         s.addr  = addr - base_m[sel];
         s.wdata = wdata;
         s.wstrb = wstrb;
         s.instr = instr;
         sq.push_back(s);
      end
      if (rst_at == 0) begin
         r.cyc   = n + rel;
         r.rdata = ok_data ? rd : 32'h0;
         r.err   = !ok_data;
         rq.push_back(r);
      end

      memory_valid = 1'b1;
      memory_addr  = addr;
      memory_wdata = wdata;
      memory_wstrb = wstrb;
      memory_instr = instr;
      // Readies while idle must be ignored, even the selected slave's.
      slave_ready  = stray ? NS'($urandom) : '0;
      slave_rdata  = {NS{$urandom}};
      txn_no++;
      $display("txn %0d: addr=%h wstrb=%b sel=%0d k=%0d stray=%0d rst_at=%0d -> expect %s rdata=%h at +%0d",
               txn_no, addr, wstrb, sel, k, stray, rst_at,
               (rst_at != 0) ? "none" : (ok_data ? "ok" : "err"), ok_data ? rd : 32'h0, rel);

      last    = ((sel >= 0 && 1 + k > rel) ? 1 + k : rel) + 2;
      aborted = 1'b0;
      for (int j = 1; j <= last; j++) begin
         @(negedge clk);
         memory_valid = 1'b0;
         slave_ready  = '0;
         // New requests while busy (including the response cycle) are dropped.
         if (!aborted && stray && j <= rel && $urandom_range(0, 3) == 0) begin
            memory_valid = 1'b1;
            memory_addr  = $urandom;
         end
         if (!aborted && stray) begin
            if (j == 1 && sel >= 0) o = (sel + 1) % NS;
            else                    o = $urandom_range(0, NS - 1);
            if (o != sel && (j == 1 || $urandom_range(0, 2) == 0)) begin
               slave_ready[o]          = 1'b1;
               slave_rdata[32*o +: 32] = (j == 1) ? 32'h1234 : $urandom;
            end
         end
         if (!aborted && sel >= 0 && j == 1 + k) begin
            slave_ready[sel]          = 1'b1;
            slave_rdata[32*sel +: 32] = rd;
         end
         if (rst_at > 0 && j == rst_at) begin
            #2 rst = 1'b0;
            aborted      = 1'b1;
            slave_ready  = '0;
            memory_valid = 1'b0;
            #1 check_reset_outputs("reset_abort");
            last_rdata = '0;
            @(negedge clk);
            @(negedge clk);
            #2 rst = 1'b1;
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int          cat;
      int          k;
      int          rel;
      int          rat;
      logic [31:0] a;

      rst          = 1'b1;
      memory_valid = 1'b0;
      memory_instr = 1'b0;
      memory_addr  = '0;
      memory_wdata = '0;
      memory_wstrb = '0;
      slave_rdata  = '0;
      slave_ready  = '0;

      #2 rst = 1'b0;
      #1 check_reset_outputs("reset_state");
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;

      // Directed scenarios
      do_txn(32'h0000_0010, 32'h0,  4'b0000, 1'b0, 0,  32'hDEAD_BEEF, 1'b0, 0);
      do_txn(32'h0010_0004, 32'hA5, 4'b0001, 1'b0, 3,  32'h0BAD_F00D, 1'b0, 0);
      do_txn(32'h0030_0000, 32'h0,  4'b0000, 1'b1, 0,  32'h1111_1111, 1'b0, 0);
      do_txn(32'h0010_0010, 32'h7,  4'b1111, 1'b0, 11, 32'h2222_2222, 1'b0, 0);
      do_txn(32'h0000_0020, 32'h0,  4'b0000, 1'b0, 5,  32'h0000_0055, 1'b1, 0);
      // Window boundaries, overlap priority and the last-cycle ready race
      do_txn(32'h000F_FFFF, 32'h1,  4'b0011, 1'b1, TO - 1, 32'hCAFE_0001, 1'b0, 0);
      do_txn(32'h0010_0000, 32'h2,  4'b0000, 1'b0, TO,     32'hCAFE_0002, 1'b0, 0);
      do_txn(32'h0010_0008, 32'h3,  4'b0100, 1'b0, 1,      32'hCAFE_0003, 1'b0, 0);
      do_txn(32'h0010_000F, 32'h4,  4'b1000, 1'b1, 2,      32'hCAFE_0004, 1'b0, 0);
      do_txn(32'h0010_001F, 32'h5,  4'b0000, 1'b0, 0,      32'hCAFE_0005, 1'b0, 0);
      do_txn(32'h0010_0020, 32'h6,  4'b0000, 1'b0, 0,      32'hCAFE_0006, 1'b1, 0);
      do_txn(32'hFFFF_FFFF, 32'h7,  4'b0000, 1'b0, 0,      32'hCAFE_0007, 1'b0, 0);
      // Reset during the wait, then a normal request
      do_txn(32'h0010_0000, 32'h8,  4'b0000, 1'b0, 6,      32'hCAFE_0008, 1'b0, 3);
      do_txn(32'h0000_0100, 32'h9,  4'b0000, 1'b0, 1,      32'hCAFE_0009, 1'b0, 0);

      // Randomised traffic
      for (int t = 0; t < 150; t++) begin
         cat = $urandom_range(0, 5);
         case (cat)
            0:       a = $urandom_range(0, 32'h000F_FFFF);
            1:       a = 32'h0010_0000 + $urandom_range(0, 15);
            2:       a = 32'h0010_0008 + $urandom_range(0, 23);
            3:       a = 32'h0010_0020 + $urandom;
            default: a = $urandom_range(0, 32'h0000_0040);
         endcase
         if (a < 32'h0010_0020 && a >= 32'h0010_0020 - 1 && cat == 3) a = 32'h0010_0020;
         k = $urandom_range(0, TO + 3);
         rat = 0;
         if (decode(a) >= 0 && $urandom_range(0, 14) == 0) begin
            rel = (k <= TO - 1) ? 2 + k : 1 + TO;
            rat = $urandom_range(1, rel - 1);
         end
         do_txn(a, $urandom, 4'($urandom), 1'($urandom), k, $urandom,
                1'($urandom_range(0, 1)), rat);
      end

      repeat (4) @(negedge clk);
      checks++;
      if (rq.size() != 0 || sq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses and %0d slave requests still expected, required 0 and 0",
                  rq.size(), sq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_interconnect.md
Name: bus_interconnect

Overview:
- Parametrised single-master, N-slave memory-bus interconnect; replaces the hand-written address-decode/ready-mux logic in the CPU top level.
- Registers each CPU request, decodes it against per-slave address windows and forwards it to exactly one slave.
- Waits for that slave's ready and returns a registered response.
- Adds behaviour the flat decoder lacks: an error response for unmapped addresses, a response timeout, and suppression of responses from unselected slaves.

Parameters:
NUM_SLAVES, 3, number of slave ports (1..16)
SLAVE_BASE, {32'h0, 32'h100000, 32'h200000} packed NUM_SLAVES*32, inclusive window base per slave (slave i at bits [32*i+31:32*i])
SLAVE_TOP, {32'h100000, 32'h100010, 32'h200010} packed NUM_SLAVES*32, exclusive window top per slave
TIMEOUT, 256, cycles to wait for slave ready before error (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
memory_valid  in  1  single-cycle request pulse from master
memory_instr  in  1  instruction-fetch flag
memory_addr  in  32  byte address
memory_wdata  in  32  write data
memory_wstrb  in  4  byte strobes; 0 = read
memory_rdata  out  32  response data
memory_ready  out  1  single-cycle response pulse
memory_error  out  1  qualifies memory_ready: unmapped address or timeout
slave_valid  out  NUM_SLAVES  one-hot single-cycle request per slave
slave_instr  out  1  latched instr, shared by all slaves
slave_addr  out  32  latched address minus selected SLAVE_BASE
slave_wdata  out  32  latched wdata, shared
slave_wstrb  out  4  latched wstrb, shared
slave_rdata  in  NUM_SLAVES*32  slave read data, slave i at [32*i+31:32*i]
slave_ready  in  NUM_SLAVES  slave response pulses

Behaviour:
- Reset (rst=0, async): state IDLE; memory_ready=0, memory_error=0, memory_rdata=0; slave_valid=0; latched instr/addr/wdata/wstrb=0; timeout counter=0.
- Decode: slave i hits when SLAVE_BASE[i] <= addr < SLAVE_TOP[i], unsigned compare.
  - Overlapping windows: lowest index wins.
  - No hit: unmapped.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On memory_valid, latch instr/addr/wdata/wstrb and the decoded index.
  - Mapped: go to REQ. Unmapped: go to RESP with error=1, rdata=0.
- REQ (one cycle):
  - slave_valid[sel]=1, all other slave_valid bits 0.
  - Clear the counter; go to WAIT.
  - If slave_ready[sel] is already 1 in this cycle, capture it as in WAIT.
- WAIT:
  - slave_ready[sel]=1: capture slave_rdata[sel], error=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ready: error=1, rdata=0, go to RESP.
- RESP (one cycle):
  - memory_ready=1; memory_rdata and memory_error hold the captured values.
  - Return to IDLE.
  - memory_rdata is held until the next response; memory_error is cleared with memory_ready.
- Latency (mapped): valid at cycle T, slave_valid at T+1, slave ready at T+1+k (k>=0), memory_ready at T+2+k. Minimum 2 cycles (k=0).
- Latency (unmapped): memory_ready with memory_error at T+1.
- memory_valid outside IDLE: ignored (no queue, no response). The master issues one outstanding request.
- Ready from an unselected slave, or any slave_ready outside REQ/WAIT: ignored. This includes a late ready after a timeout.
- slave_addr, slave_wdata, slave_wstrb, slave_instr: stable from REQ until the next accepted request.
- Simultaneous: slave ready in the same cycle the counter reaches TIMEOUT-1 → the ready wins (error=0).
- Reset mid-transaction: immediate abort to the reset values; no response is ever issued for the aborted request.

Test Plan:
- Read slave 0: memory_valid, addr=32'h10, wstrb=0; slave 0 answers ready with rdata=32'hDEADBEEF at k=0 → slave_valid=3'b001 and slave_addr=32'h10 at T+1; memory_ready=1, rdata=32'hDEADBEEF, error=0 at T+2.
- Write slave 1: addr=32'h100004, wdata=32'hA5, wstrb=4'b0001; ready at k=3 → slave_valid=3'b010, slave_addr=32'h4, wstrb=4'b0001; memory_ready at T+5, error=0.
- Unmapped: addr=32'h300000 → no slave_valid ever; memory_ready=1, error=1, rdata=0 at T+1.
- Timeout (TIMEOUT=8): request to slave 2, slave never ready → memory_ready with error=1 at T+9. A late slave_ready[2] at T+12 causes no response.
- Stray ready: during WAIT on slave 0, pulse slave_ready[1] with rdata=32'h1234 → ignored. A later slave_ready[0] with rdata=32'h55 returns 32'h55.
- Reset: drop rst to 0 during WAIT → all outputs 0 asynchronously. After rst returns to 1, no memory_ready occurs, and the next request completes normally.
